// File: rtl/elm_pkg.sv
// Shared definitions for the weight memory loader and the per-neuron weight memories:
// loader state encoding, header field offsets and default memory geometry.
package elm_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 10;

  // Header beat: neuron index in the low half, layer id in the high half.
  localparam int NEURON_LSB = 0;

  function automatic int layer_lsb(input int data_width);
    return data_width;
  endfunction

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LO    = 3'd1,
    HI    = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } wl_state_e;

endpackage

// File: rtl/weight_mem_loader.sv
// Streams packed weight pairs into the weight RAM of one neuron of layer layerNo.
// Optional running checksum of written data when WLOAD_CHECKSUM_EN is defined.
module weight_mem_loader
  import elm_pkg::*;
#(
  parameter int layerNo      = 1,
  parameter int neuronNo     = 16,
  parameter int numWeight    = 784,
  parameter int addressWidth = ADDR_WIDTH,
  parameter int dataWidth    = DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [2*dataWidth-1:0]  s_tdata,
  input  logic                    s_tvalid,
  input  logic                    s_tlast,
  output logic                    s_tready,
  output logic [neuronNo-1:0]     wen,
  output logic [addressWidth:0]   waddr,
  output logic [dataWidth-1:0]    win,
  output logic                    busy,
  output logic                    load_done,
  output logic                    err_hdr,
`ifdef WLOAD_CHECKSUM_EN
  output logic [dataWidth-1:0]    checksum,
`endif
  output logic                    err_len
);

  localparam int CNT_W  = addressWidth + 1;
  localparam int NIDX_W = (neuronNo > 1) ? $clog2(neuronNo) : 1;
  localparam int LAY_LSB = layer_lsb(dataWidth);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(numWeight - 1);

  // Handshake contract: a beat transfers on a rising clk edge where s_tvalid
  // and s_tready are both high; s_tready depends only on the loader state.

  wl_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NIDX_W-1:0]    neuron_q, neuron_d;
  logic [dataWidth-1:0] hi_q, hi_d;
  logic                 last_q, last_d;

  logic                 s_tready_q, s_tready_d;
  logic [neuronNo-1:0]  wen_q, wen_d;
  logic [CNT_W-1:0]     waddr_q, waddr_d;
  logic [dataWidth-1:0] win_q, win_d;
  logic                 busy_q, busy_d;
  logic                 load_done_q, load_done_d;
  logic                 err_hdr_q, err_hdr_d;
  logic                 err_len_q, err_len_d;

  logic                 hs;
  logic                 hdr_hs;
  logic                 hdr_bad;
  logic                 last_weight;

  assign hs          = s_tvalid & s_tready_q;
  assign hdr_hs      = hs && (state_q == IDLE);
  assign hdr_bad     = (s_tdata[LAY_LSB +: dataWidth] != dataWidth'(layerNo)) ||
                       (s_tdata[NEURON_LSB +: dataWidth] >= dataWidth'(neuronNo));
  assign last_weight = (cnt_q == LAST_IDX);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    neuron_d    = neuron_q;
    hi_d        = hi_q;
    last_d      = last_q;
    wen_d       = '0;
    waddr_d     = waddr_q;
    win_d       = win_q;
    err_hdr_d   = err_hdr_q;
    err_len_d   = err_len_q;

    case (state_q)
      IDLE: begin
        if (hs) begin
          err_hdr_d = 1'b0;
          err_len_d = 1'b0;
          cnt_d     = '0;
          neuron_d  = s_tdata[NEURON_LSB +: NIDX_W];
          if (hdr_bad) begin
            err_hdr_d = 1'b1;
            state_d   = s_tlast ? IDLE : DRAIN;
          end else if (s_tlast) begin
            err_len_d = 1'b1;
          end else begin
            state_d = LO;
          end
        end
      end

      LO: begin
        if (hs) begin
          for (int i = 0; i < neuronNo; i++) wen_d[i] = (int'(neuron_q) == i);
          waddr_d = cnt_q;
          win_d   = s_tdata[dataWidth-1:0];
          hi_d    = s_tdata[2*dataWidth-1:dataWidth];
          last_d  = s_tlast;
          cnt_d   = cnt_q + CNT_W'(1);
          if (last_weight) begin
            // Odd count: the high half of the final beat is padding.
            if (s_tlast) begin
              state_d = DONE;
            end else begin
              state_d   = DRAIN;
              err_len_d = 1'b1;
            end
          end else begin
            state_d = HI;
          end
        end
      end

      HI: begin
        for (int i = 0; i < neuronNo; i++) wen_d[i] = (int'(neuron_q) == i);
        waddr_d = cnt_q;
        win_d   = hi_q;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_weight) begin
          if (last_q) begin
            state_d = DONE;
          end else begin
            state_d   = DRAIN;
            err_len_d = 1'b1;
          end
        end else if (last_q) begin
          state_d   = IDLE;
          err_len_d = 1'b1;
        end else begin
          state_d = LO;
        end
      end

      DRAIN: begin
        if (hs && s_tlast) state_d = IDLE;
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    s_tready_d  = (state_d == IDLE) || (state_d == LO) || (state_d == DRAIN);
    busy_d      = (state_d != IDLE);
    load_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      neuron_q    <= '0;
      hi_q        <= '0;
      last_q      <= 1'b0;
      s_tready_q  <= 1'b0;
      wen_q       <= '0;
      waddr_q     <= '0;
      win_q       <= '0;
      busy_q      <= 1'b0;
      load_done_q <= 1'b0;
      err_hdr_q   <= 1'b0;
      err_len_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      neuron_q    <= neuron_d;
      hi_q        <= hi_d;
      last_q      <= last_d;
      s_tready_q  <= s_tready_d;
      wen_q       <= wen_d;
      waddr_q     <= waddr_d;
      win_q       <= win_d;
      busy_q      <= busy_d;
      load_done_q <= load_done_d;
      err_hdr_q   <= err_hdr_d;
      err_len_q   <= err_len_d;
    end
  end

`ifdef WLOAD_CHECKSUM_EN
  logic [dataWidth-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (hdr_hs)      csum_d = '0;
    else if (|wen_d) csum_d = csum_q + win_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) csum_q <= '0;
    else        csum_q <= csum_d;
  end

  assign checksum = csum_q;
`endif

  assign s_tready  = s_tready_q;
  assign wen       = wen_q;
  assign waddr     = waddr_q;
  assign win       = win_q;
  assign busy      = busy_q;
  assign load_done = load_done_q;
  assign err_hdr   = err_hdr_q;
  assign err_len   = err_len_q;

endmodule

// File: tb/tb_weight_mem_loader.sv
// Bench for weight_mem_loader: one instance with an even weight count (4), one with an odd count (3).
// Checksum checks are compiled in when WLOAD_CHECKSUM_EN is defined.
module tb_weight_mem_loader;

  logic        clk;
  logic        rst_n;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tlast;
  logic        sel;

  logic        tvalid4, tready4, busy4, done_p4, err_hdr4, err_len4;
  logic [15:0] wen4;
  logic [10:0] waddr4;
  logic [15:0] win4;
  logic        tvalid3, tready3, busy3, done_p3, err_hdr3, err_len3;
  logic [15:0] wen3;
  logic [10:0] waddr3;
  logic [15:0] win3;
`ifdef WLOAD_CHECKSUM_EN
  logic [15:0] checksum4, checksum3;
`endif

  logic        rdy, busy_sel;
  assign tvalid4  = s_tvalid & ~sel;
  assign tvalid3  = s_tvalid & sel;
  assign rdy      = sel ? tready3 : tready4;
  assign busy_sel = sel ? busy3 : busy4;

  weight_mem_loader #(
    .layerNo(1), .neuronNo(16), .numWeight(4), .addressWidth(10), .dataWidth(16)
  ) u_dut4 (
    .clk(clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tvalid(tvalid4), .s_tlast(s_tlast),
    .s_tready(tready4), .wen(wen4), .waddr(waddr4), .win(win4), .busy(busy4),
    .load_done(done_p4), .err_hdr(err_hdr4),
`ifdef WLOAD_CHECKSUM_EN
    .checksum(checksum4),
`endif
    .err_len(err_len4)
  );

  weight_mem_loader #(
    .layerNo(1), .neuronNo(16), .numWeight(3), .addressWidth(10), .dataWidth(16)
  ) u_dut3 (
    .clk(clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tvalid(tvalid3), .s_tlast(s_tlast),
    .s_tready(tready3), .wen(wen3), .waddr(waddr3), .win(win3), .busy(busy3),
    .load_done(done_p3), .err_hdr(err_hdr3),
`ifdef WLOAD_CHECKSUM_EN
    .checksum(checksum3),
`endif
    .err_len(err_len3)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 300000");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  int done4    = 0;
  int done3    = 0;
  logic [42:0] exp4_q[$];
  logic [42:0] exp3_q[$];
  logic [42:0] e4, e3;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [42:0] mk_wr(input int neuron, input int addr, input logic [15:0] data);
    logic [15:0] oh;
    oh = 16'd1 << neuron;
    return {oh, 11'(addr), data};
  endfunction

  always @(negedge clk) begin
    if (done_p4) done4++;
    if (wen4 != '0) begin
      if (exp4_q.size() == 0) check_val("wr4_unexpected", {wen4, waddr4, win4}, '0);
      else begin
        e4 = exp4_q.pop_front();
        check_val("wr4", {wen4, waddr4, win4}, e4);
      end
    end
  end

  always @(negedge clk) begin
    if (done_p3) done3++;
    if (wen3 != '0) begin
      if (exp3_q.size() == 0) check_val("wr3_unexpected", {wen3, waddr3, win3}, '0);
      else begin
        e3 = exp3_q.pop_front();
        check_val("wr3", {wen3, waddr3, win3}, e3);
      end
    end
  end

  // drivers
  task automatic send_beat(input logic [31:0] data, input logic last, output int waits);
    s_tdata  = data;
    s_tlast  = last;
    s_tvalid = 1'b1;
    waits    = 0;
    @(negedge clk);
    while (!rdy && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!rdy) check_val("handshake_timeout", rdy, 1);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy_sel && n < 50) begin
      n++;
      @(negedge clk);
    end
    check_val("idle_timeout", busy_sel, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic good_load4(input int neuron, input logic [15:0] w0, w1, w2, w3);
    int d0, wt;
    logic [15:0] sum;
    sel = 1'b0;
    d0  = done4;
    sum = w0 + w1 + w2 + w3;
    exp4_q.push_back(mk_wr(neuron, 0, w0));
    exp4_q.push_back(mk_wr(neuron, 1, w1));
    exp4_q.push_back(mk_wr(neuron, 2, w2));
    exp4_q.push_back(mk_wr(neuron, 3, w3));
    send_beat({16'd1, 16'(neuron)}, 1'b0, wt);
    send_beat({w1, w0}, 1'b0, wt);
    send_beat({w3, w2}, 1'b1, wt);
    wait_idle();
    check_val("load4_done", done4 - d0, 1);
    check_val("load4_err_hdr", err_hdr4, 0);
    check_val("load4_err_len", err_len4, 0);
    check_val("load4_pending", exp4_q.size(), 0);
`ifdef WLOAD_CHECKSUM_EN
    check_val("load4_checksum", checksum4, sum);
`endif
  endtask

  task automatic good_load3(input int neuron, input logic [15:0] w0, w1, w2, junk);
    int d0, wt;
    logic [15:0] sum;
    sel = 1'b1;
    d0  = done3;
    sum = w0 + w1 + w2;
    exp3_q.push_back(mk_wr(neuron, 0, w0));
    exp3_q.push_back(mk_wr(neuron, 1, w1));
    exp3_q.push_back(mk_wr(neuron, 2, w2));
    send_beat({16'd1, 16'(neuron)}, 1'b0, wt);
    send_beat({w1, w0}, 1'b0, wt);
    send_beat({junk, w2}, 1'b1, wt);
    wait_idle();
    check_val("load3_done", done3 - d0, 1);
    check_val("load3_err_hdr", err_hdr3, 0);
    check_val("load3_err_len", err_len3, 0);
    check_val("load3_pending", exp3_q.size(), 0);
`ifdef WLOAD_CHECKSUM_EN
    check_val("load3_checksum", checksum3, sum);
`endif
    sel = 1'b0;
  endtask

  task automatic check_zero4(input string tag);
    check_val({tag, "_wen"},       wen4, 0);
    check_val({tag, "_waddr"},     waddr4, 0);
    check_val({tag, "_win"},       win4, 0);
    check_val({tag, "_busy"},      busy4, 0);
    check_val({tag, "_load_done"}, done_p4, 0);
    check_val({tag, "_err_hdr"},   err_hdr4, 0);
    check_val({tag, "_err_len"},   err_len4, 0);
    check_val({tag, "_tready"},    tready4, 0);
  endtask

  // main sequence
  initial begin
    int wt, d0;
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    sel      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero4("reset");
    check_val("reset_tready3", tready3, 0);
    check_val("reset_busy3", busy3, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // even-length load, final weight in the high half
    good_load4(3, 16'd1, 16'd2, 16'd3, 16'd4);

    // odd-length load, high half of the final beat discarded
    good_load3(0, 16'd1, 16'd2, 16'd3, 16'hBEEF);

    // valid header carrying tlast
    d0 = done4;
    send_beat({16'd1, 16'd0}, 1'b1, wt);
    wait_idle();
    check_val("hdr_last_err_len", err_len4, 1);
    check_val("hdr_last_err_hdr", err_hdr4, 0);

    // neuron index out of range, header carrying tlast
    send_beat({16'd1, 16'd16}, 1'b1, wt);
    wait_idle();
    check_val("bad_neuron_err_hdr", err_hdr4, 1);
    check_val("bad_neuron_err_len", err_len4, 0);

    // wrong layer, three beats drained with s_tready held high
    send_beat({16'd2, 16'd0}, 1'b0, wt);
    check_val("drain_hdr_wait", wt, 0);
    check_val("drain_busy", busy4, 1);
    for (int i = 0; i < 3; i++) begin
      send_beat($urandom(), (i == 2), wt);
      check_val("drain_beat_wait", wt, 0);
    end
    wait_idle();
    check_val("drain_err_hdr", err_hdr4, 1);
    check_val("drain_err_len", err_len4, 0);
    check_val("drain_tready", tready4, 1);
    check_val("err_no_done", done4 - d0, 0);

    // tlast too early: one beat of a four-weight load
    d0 = done4;
    exp4_q.push_back(mk_wr(5, 0, 16'd5));
    exp4_q.push_back(mk_wr(5, 1, 16'd6));
    send_beat({16'd1, 16'd5}, 1'b0, wt);
    check_val("early_hdr_clears_err_hdr", err_hdr4, 0);
    send_beat({16'd6, 16'd5}, 1'b1, wt);
    wait_idle();
    check_val("early_err_len", err_len4, 1);
    check_val("early_err_hdr", err_hdr4, 0);
    check_val("early_pending", exp4_q.size(), 0);

    // next header clears err_len; tlast too late, third beat drained
    exp4_q.push_back(mk_wr(1, 0, 16'd1));
    exp4_q.push_back(mk_wr(1, 1, 16'd2));
    exp4_q.push_back(mk_wr(1, 2, 16'd3));
    exp4_q.push_back(mk_wr(1, 3, 16'd4));
    send_beat({16'd1, 16'd1}, 1'b0, wt);
    check_val("late_hdr_clears_err_len", err_len4, 0);
    send_beat({16'd2, 16'd1}, 1'b0, wt);
    send_beat({16'd4, 16'd3}, 1'b0, wt);
    send_beat({16'h5555, 16'hAAAA}, 1'b1, wt);
    wait_idle();
    check_val("late_err_len", err_len4, 1);
    check_val("late_pending", exp4_q.size(), 0);
    check_val("len_err_no_done", done4 - d0, 0);

    // reset while the high half is pending
    exp4_q.push_back(mk_wr(7, 0, 16'd7));
    send_beat({16'd1, 16'd7}, 1'b0, wt);
    send_beat({16'd8, 16'd7}, 1'b0, wt);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_zero4("midload_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_val("midload_pending", exp4_q.size(), 0);
    good_load4(3, 16'd1, 16'd2, 16'd3, 16'd4);

    // random well-formed loads on both instances
    for (int i = 0; i < 4; i++) begin
      good_load4($urandom_range(0, 15), 16'($urandom()), 16'($urandom()),
                 16'($urandom()), 16'($urandom()));
      good_load3($urandom_range(0, 15), 16'($urandom()), 16'($urandom()),
                 16'($urandom()), 16'($urandom()));
    end

    repeat (3) @(posedge clk);
    check_val("final_pending4", exp4_q.size(), 0);
    check_val("final_pending3", exp3_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
